// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and data access.
// Data has fixed priority, except that fetch wins once it has lost STARVE_LIMIT cycles in a row.
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inst_req,
  input  logic [AW-1:0] i_inst_addr,
  input  logic          i_inst_kill,
  output logic          o_inst_gnt,
  output logic          o_inst_rvalid,
  output logic [DW-1:0] o_inst_rdata,
  input  logic          i_data_req,
  input  logic [3:0]    i_data_wen,
  input  logic [AW-1:0] i_data_addr,
  input  logic [DW-1:0] i_data_wdata,
  output logic          o_data_gnt,
  output logic          o_data_rvalid,
  output logic [DW-1:0] o_data_rdata,
  output logic          o_mem_en,
  output logic [3:0]    o_mem_wen,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_stallreq_for_arb
);

  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_INST,
    PEND_DATA
  } pend_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  pend_e         r_pend;
  logic [3:0]    r_starve_cnt;
  logic [DW-1:0] r_inst_hold;
  logic [DW-1:0] r_data_hold;

  logic w_starved;
  logic w_data_gnt;
  logic w_inst_gnt;
  logic w_inst_rvalid;
  logic w_data_rvalid;

  // Combinational outputs are qualified with rst_n so they read zero during reset.
  assign w_starved     = (r_starve_cnt == LIMIT);
  assign w_data_gnt    = rst_n & i_data_req & ~(i_inst_req & w_starved);
  assign w_inst_gnt    = rst_n & i_inst_req & ~w_data_gnt;
  assign w_inst_rvalid = rst_n & (r_pend == PEND_INST) & ~i_inst_kill;
  assign w_data_rvalid = rst_n & (r_pend == PEND_DATA);

  assign o_inst_gnt         = w_inst_gnt;
  assign o_data_gnt         = w_data_gnt;
  assign o_inst_rvalid      = w_inst_rvalid;
  assign o_data_rvalid      = w_data_rvalid;
  assign o_inst_rdata       = w_inst_rvalid ? i_mem_rdata : r_inst_hold;
  assign o_data_rdata       = w_data_rvalid ? i_mem_rdata : r_data_hold;
  assign o_stallreq_for_arb = rst_n & ((i_inst_req & ~w_inst_gnt) | (i_data_req & ~w_data_gnt));

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_wen   = 4'h0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_data_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_wen   = i_data_wen;
      o_mem_addr  = i_data_addr;
      o_mem_wdata = i_data_wdata;
    end else if (w_inst_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_inst_addr;
    end
  end

  // Counts consecutive cycles fetch lost to data; any other cycle restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'h0;
    end else if (i_inst_req && i_data_req && w_data_gnt) begin
      r_starve_cnt <= w_starved ? LIMIT : r_starve_cnt + 4'h1;
    end else begin
      r_starve_cnt <= 4'h0;
    end
  end

  // Remembers who owns the read data arriving next cycle; writes return nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= PEND_NONE;
    end else if (w_inst_gnt) begin
      r_pend <= PEND_INST;
    end else if (w_data_gnt && (i_data_wen == 4'h0)) begin
      r_pend <= PEND_DATA;
    end else begin
      r_pend <= PEND_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst_hold <= '0;
      r_data_hold <= '0;
    end else begin
      if (w_inst_rvalid) r_inst_hold <= i_mem_rdata;
      if (w_data_rvalid) r_data_hold <= i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios followed by random traffic,
// all compared against a cycle-level model built from the arbitration rules.
module tb_sram_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        i_inst_req;
  logic [31:0] i_inst_addr;
  logic        i_inst_kill;
  logic        o_inst_gnt;
  logic        o_inst_rvalid;
  logic [31:0] o_inst_rdata;
  logic        i_data_req;
  logic [3:0]  i_data_wen;
  logic [31:0] i_data_addr;
  logic [31:0] i_data_wdata;
  logic        o_data_gnt;
  logic        o_data_rvalid;
  logic [31:0] o_data_rdata;
  logic        o_mem_en;
  logic [3:0]  o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        o_stallreq_for_arb;

  sram_port_arbiter #(.STARVE_LIMIT(LIMIT), .AW(32), .DW(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_inst_req         (i_inst_req),
    .i_inst_addr        (i_inst_addr),
    .i_inst_kill        (i_inst_kill),
    .o_inst_gnt         (o_inst_gnt),
    .o_inst_rvalid      (o_inst_rvalid),
    .o_inst_rdata       (o_inst_rdata),
    .i_data_req         (i_data_req),
    .i_data_wen         (i_data_wen),
    .i_data_addr        (i_data_addr),
    .i_data_wdata       (i_data_wdata),
    .o_data_gnt         (o_data_gnt),
    .o_data_rvalid      (o_data_rvalid),
    .o_data_rdata       (o_data_rdata),
    .o_mem_en           (o_mem_en),
    .o_mem_wen          (o_mem_wen),
    .o_mem_addr         (o_mem_addr),
    .o_mem_wdata        (o_mem_wdata),
    .i_mem_rdata        (i_mem_rdata),
    .o_stallreq_for_arb (o_stallreq_for_arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Model state: consecutive fetch losses, owner of the next response (0 none, 1 fetch, 2 data).
  int          mLosses = 0;
  int          mOwner  = 0;
  logic [31:0] mIHold  = 32'h0;
  logic [31:0] mDHold  = 32'h0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drives one cycle of inputs after the falling edge, checks the outputs, then advances the model.
  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic ik,
                               input logic dr, input logic [3:0] dw, input logic [31:0] da,
                               input logic [31:0] dd, input logic [31:0] mr);
    logic        eIG, eDG, eIV, eDV, eStall;
    logic [31:0] eAddr, eWdata, eIRd, eDRd;
    logic [3:0]  eWen;
    @(negedge clk);
    i_inst_req = ir; i_inst_addr = ia; i_inst_kill = ik;
    i_data_req = dr; i_data_wen = dw; i_data_addr = da; i_data_wdata = dd;
    i_mem_rdata = mr;
    #1;
    if (!rst_n) begin
      mLosses = 0; mOwner = 0; mIHold = 32'h0; mDHold = 32'h0;
      eIG = 0; eDG = 0; eIV = 0; eDV = 0; eStall = 0;
      eAddr = 0; eWdata = 0; eWen = 0; eIRd = 0; eDRd = 0;
    end else begin
      eDG    = dr && !(ir && mLosses == LIMIT);
      eIG    = ir && !eDG;
      eAddr  = eDG ? da : (eIG ? ia : 32'h0);
      eWen   = eDG ? dw : 4'h0;
      eWdata = eDG ? dd : 32'h0;
      eStall = (ir && !eIG) || (dr && !eDG);
      eIV    = (mOwner == 1) && !ik;
      eDV    = (mOwner == 2);
      eIRd   = eIV ? mr : mIHold;
      eDRd   = eDV ? mr : mDHold;
    end
    checkOutput("instGnt",  32'(o_inst_gnt),         32'(eIG));
    checkOutput("dataGnt",  32'(o_data_gnt),         32'(eDG));
    checkOutput("memEn",    32'(o_mem_en),           32'(eIG | eDG));
    checkOutput("memWen",   32'(o_mem_wen),          32'(eWen));
    checkOutput("memAddr",  o_mem_addr,              eAddr);
    checkOutput("memWdata", o_mem_wdata,             eWdata);
    checkOutput("stallReq", 32'(o_stallreq_for_arb), 32'(eStall));
    checkOutput("instRv",   32'(o_inst_rvalid),      32'(eIV));
    checkOutput("instRd",   o_inst_rdata,            eIRd);
    checkOutput("dataRv",   32'(o_data_rvalid),      32'(eDV));
    checkOutput("dataRd",   o_data_rdata,            eDRd);
    if (rst_n) begin
      if (eIV) mIHold = mr;
      if (eDV) mDHold = mr;
      mLosses = (ir && dr && eDG) ? ((mLosses + 1 > LIMIT) ? LIMIT : mLosses + 1) : 0;
      mOwner  = eIG ? 1 : ((eDG && dw == 4'h0) ? 2 : 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_inst_req = 0; i_inst_addr = 0; i_inst_kill = 0;
    i_data_req = 0; i_data_wen = 0; i_data_addr = 0; i_data_wdata = 0;
    i_mem_rdata = 0;

    // Reset and idle.
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 32'hA5A5A5A5);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 32'h5A5A5A5A);

    // Lone fetch, response next cycle, then held.
    applyStimulus(1, 32'hBFC00000, 0, 0, 4'h0, 0, 0, 32'hCAFEF00D);
    checkOutput("fetchAddr", o_mem_addr, 32'hBFC00000);
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 32'h24080001);
    checkOutput("fetchData", o_inst_rdata, 32'h24080001);
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 32'h77777777);
    checkOutput("fetchHold", o_inst_rdata, 32'h24080001);

    // Killed fetch response leaves the held value alone.
    applyStimulus(1, 32'hBFC00004, 0, 0, 4'h0, 0, 0, 32'h0);
    applyStimulus(0, 0, 1, 0, 4'h0, 0, 0, 32'h11111111);
    checkOutput("killRvalid", 32'(o_inst_rvalid), 32'h0);
    checkOutput("killHold", o_inst_rdata, 32'h24080001);

    // Store collides with fetch: data wins, no response afterwards.
    applyStimulus(1, 32'hBFC00008, 0, 1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0);
    checkOutput("storeWdata", o_mem_wdata, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 32'h12345678);
    checkOutput("storeNoRv", 32'(o_data_rvalid), 32'h0);

    // Continuous contention: fetch must win on cycles 4 and 9.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 32'h1000 + 32'(i * 4), 0, 1, 4'h0, 32'h200 + 32'(i * 4), 0, $urandom);
      checkOutput("starveGnt", 32'(o_inst_gnt), 32'((i == 4) || (i == 9)));
    end
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, $urandom);

    // Data read granted, reset lands before its response.
    applyStimulus(0, 0, 0, 1, 4'h0, 32'h300, 0, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    applyStimulus(1, 32'h400, 0, 1, 4'h0, 32'h304, 0, 32'h55555555);
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 32'h66666666);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 32'h99999999);
    checkOutput("noStrayRv", 32'(o_data_rvalid), 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                    $urandom, $urandom, $urandom);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency) between the fetch requester (IF) and the data requester (EX/MEM).
- Grants at most one access per cycle, with fixed data priority and a starvation guard for fetch.
- Routes read data back to the owning requester and holds it across stalls.
- Raises a stall request toward the pipeline CTRL block whenever a request is refused.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles fetch may lose to data before fetch is forced to win; legal range 1..15.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request
- inst_addr  in  AW  fetch address
- inst_kill  in  1  discard the fetch response due this cycle (branch redirect)
- inst_gnt  out  1  fetch request accepted this cycle
- inst_rvalid  out  1  fetch read data valid this cycle
- inst_rdata  out  DW  fetch read data; holds last value when rvalid is low
- data_req  in  1  data request
- data_wen  in  4  byte write enables; 0 means read
- data_addr  in  AW  data address
- data_wdata  in  DW  store data
- data_gnt  out  1  data request accepted this cycle
- data_rvalid  out  1  data read data valid this cycle
- data_rdata  out  DW  data read data; holds last value
- mem_en  out  1  SRAM enable
- mem_wen  out  4  SRAM byte write enables
- mem_addr  out  AW  SRAM address
- mem_wdata  out  DW  SRAM write data
- mem_rdata  in  DW  SRAM read data, valid one cycle after a read issue
- stallreq_for_arb  out  1  to CTRL: some request was refused this cycle

Behaviour:
Grant (combinational, same cycle as request):
- Only data_req: data granted.
- Only inst_req: inst granted.
- Both asserted: data granted unless starve_cnt == STARVE_LIMIT, in which case inst is granted.
- No request: mem_en=0; mem_wen, mem_addr, mem_wdata driven 0.
- Winner's address and wen drive the SRAM. Fetch is always a read (mem_wen=0). mem_wdata=data_wdata on a data grant, else 0.
- stallreq_for_arb = (inst_req & ~inst_gnt) | (data_req & ~data_gnt).

starve_cnt (registered, width 4):
- Increments when both requests are present and data wins.
- Clears when inst is granted or inst_req is low.
- Saturates at STARVE_LIMIT.

Response FSM, registered state `pend`:
- States: NONE, INST, DATA.
- Next state is INST on an inst grant, DATA on a data read grant (data_wen==0), NONE otherwise. This includes data writes, which produce no rvalid.

Response outputs:
- inst_rvalid = (pend==INST) & ~inst_kill.
- data_rvalid = (pend==DATA). Not affected by inst_kill.
- inst_rdata = inst_rvalid ? mem_rdata : inst_hold.
- data_rdata likewise, using data_hold.
- inst_hold captures mem_rdata on inst_rvalid; data_hold captures mem_rdata on data_rvalid.
- Killed responses do not update inst_hold.

Latency and pipelining:
- Read data arrives exactly 1 cycle after the grant.
- Back-to-back grants are allowed every cycle, e.g. inst, data, inst: each response appears in the following cycle.

Reset (rst low, asynchronous):
- pend=NONE, starve_cnt=0, holds=0.
- All outputs 0: rvalids 0, rdata 0, gnts 0, mem_* 0, stall 0.
- Combinational outputs are forced 0 while rst is low.
- A response pending at reset assertion is dropped and never delivered after reset release.

Boundary rules:
- A request refused this cycle must be re-presented by the requester with the same payload. The arbiter keeps no copy.
- inst_kill is ignored when pend!=INST.

Test Plan:
- Reset then idle, no requests -> mem_en=0, both gnt=0, stallreq_for_arb=0, rvalids=0, rdata=0.
- inst_req only, addr 0xBFC00000; SRAM returns 0x24080001 the next cycle -> inst_gnt=1, mem_addr=0xBFC00000, mem_wen=0; next cycle inst_rvalid=1, inst_rdata=0x24080001; afterwards inst_rdata holds 0x24080001.
- Both requesting in the same cycle; data is a store with wen=4'hF, addr 0x100, wdata 0xDEADBEEF -> data_gnt=1, inst_gnt=0, mem_wen=F, mem_wdata=0xDEADBEEF, stallreq_for_arb=1; next cycle data_rvalid=0.
- Both requesting continuously, data reads, STARVE_LIMIT=4 -> data wins cycles 0-3, inst wins cycle 4, data wins cycles 5-8, inst wins cycle 9. stallreq_for_arb=1 every cycle. Each response is routed to its owner one cycle after its grant.
- inst granted, inst_kill=1 in the response cycle with mem_rdata=0x11111111 -> inst_rvalid=0, inst_rdata keeps its previous value.
- Data read granted, then rst driven low before the response cycle -> data_rvalid=0 during reset; after release pend=NONE and no stray rvalid.
